// File: rtl/riscv8_pkg.sv
// Shared types and widths for the 8-bit datapath (register file, fetch, execute).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv8_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int OP_W     = 4;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [OP_W-1:0]     op_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  // True when the writeback bus is writing register ra this cycle.
  function automatic logic wb_hit(input logic we, input reg_addr_t wa, input reg_addr_t ra);
    return we && (wa == ra);
  endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of all operand-fetch signals: decode handshake, RF read port, writeback, issue handshake.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs.
// Ports: master = the fetch stage (drives in_ready, ra*, out_*, busy); slave = surrounding pipeline.
interface operand_fetch_stage_if;
  import riscv8_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  reg_addr_t in_rd;
  logic      in_wen;
  op_t       in_op;
  data_t     in_imm;

  reg_addr_t ra1;
  reg_addr_t ra2;
  data_t     rd1;
  data_t     rd2;

  logic      wb_we;
  reg_addr_t wb_addr;
  data_t     wb_data;

  logic      out_valid;
  logic      out_ready;
  data_t     out_a;
  data_t     out_b;
  reg_addr_t out_rd;
  logic      out_wen;
  op_t       out_op;
  data_t     out_imm;

  reg_mask_t busy;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wen, in_op, in_imm,
    input  rd1, rd2, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, ra1, ra2, out_valid, out_a, out_b, out_rd, out_wen,
    output out_op, out_imm, busy
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_wen, in_op, in_imm,
    output rd1, rd2, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, ra1, ra2, out_valid, out_a, out_b, out_rd, out_wen,
    input  out_op, out_imm, busy
  );
endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, cleared by writeback, set on issue.
// Latency: 1 cycle (busy reflects updates after the edge).
// Backpressure: none; set/clear are single-cycle strobes.
// Ports: clk, rst (sync active-low), wb_we/wb_addr clear port, set_en/set_addr set port, busy out.
module reg_scoreboard
  import riscv8_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_we,
  input  reg_addr_t wb_addr,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  output reg_mask_t busy
);

  reg_mask_t busy_nxt;

  // Clear first, then set, so an issue to a register retiring this same
  // cycle leaves it busy for the new producer. $0 is never pending.
  always_comb begin
    busy_nxt = busy;
    if (wb_we)  busy_nxt[wb_addr]  = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch/issue: RF read addressing, writeback bypass, RAW stall on scoreboard, output register.
// Latency: ra* 0 cycles; operands on out_* 1 cycle after an accepted instruction.
// Backpressure: in_ready drops on a RAW hazard or when the held output is not taken; out_* hold while stalled.
// Ports: clk, rst (sync active-low), bus (operand_fetch_stage_if.master).
module operand_fetch_stage
  import riscv8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  operand_fetch_stage_if.master bus
);

  reg_mask_t busy;
  logic      byp1, byp2;
  logic      haz1, haz2;
  logic      fire;
  data_t     a_res, b_res;

  logic      out_valid_q;
  data_t     out_a_q, out_b_q, out_imm_q;
  reg_addr_t out_rd_q;
  logic      out_wen_q;
  op_t       out_op_q;

  assign bus.ra1 = bus.in_rs1;
  assign bus.ra2 = bus.in_rs2;

  assign byp1 = wb_hit(bus.wb_we, bus.wb_addr, bus.in_rs1);
  assign byp2 = wb_hit(bus.wb_we, bus.wb_addr, bus.in_rs2);

  // $0 reads as zero ahead of any bypass so a stray writeback to $0 can't leak in.
  assign a_res = (bus.in_rs1 == '0) ? '0 : (byp1 ? bus.wb_data : bus.rd1);
  assign b_res = (bus.in_rs2 == '0) ? '0 : (byp2 ? bus.wb_data : bus.rd2);

  // A writeback landing this cycle resolves the hazard; the bypass supplies its data.
  assign haz1 = (bus.in_rs1 != '0) && busy[bus.in_rs1] && !byp1;
  assign haz2 = (bus.in_rs2 != '0) && busy[bus.in_rs2] && !byp2;

  assign bus.in_ready = !(haz1 || haz2) && (!out_valid_q || bus.out_ready);
  assign fire         = bus.in_valid && bus.in_ready;

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (bus.wb_we),
    .wb_addr  (bus.wb_addr),
    .set_en   (fire && bus.in_wen && (bus.in_rd != '0)),
    .set_addr (bus.in_rd),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      out_op_q    <= '0;
      out_imm_q   <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_a_q     <= a_res;
      out_b_q     <= b_res;
      out_rd_q    <= bus.in_rd;
      out_wen_q   <= bus.in_wen;
      out_op_q    <= bus.in_op;
      out_imm_q   <= bus.in_imm;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_wen   = out_wen_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  import riscv8_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  operand_fetch_stage_if bus ();

  operand_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      v;
    reg_addr_t rs1, rs2, rd;
    logic      wen;
    op_t       op;
    data_t     rd1, rd2;
    logic      we;
    reg_addr_t wa;
    data_t     wd;
    logic      ordy;
    logic      x_rdy;
    logic      x_ov;
    data_t     x_a, x_b;
    reg_addr_t x_rd;
    op_t       x_op;
    reg_mask_t x_busy;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t, input data_t imm);
    bus.in_valid  = t.v;
    bus.in_rs1    = t.rs1;
    bus.in_rs2    = t.rs2;
    bus.in_rd     = t.rd;
    bus.in_wen    = t.wen;
    bus.in_op     = t.op;
    bus.in_imm    = imm;
    bus.rd1       = t.rd1;
    bus.rd2       = t.rd2;
    bus.wb_we     = t.we;
    bus.wb_addr   = t.wa;
    bus.wb_data   = t.wd;
    bus.out_ready = t.ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            v     rs1   rs2   rd    wen   op    rd1     rd2     we    wa    wd      ordy | rdy  ov    a       b       rd    op    busy
    vecs[0]  = '{1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 4'h5, 8'h12, 8'h34, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 3'd3, 4'h5, 8'h08};
    vecs[1]  = '{1'b1, 3'd3, 3'd2, 3'd4, 1'b1, 4'h6, 8'hAA, 8'hBB, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 3'd3, 4'h5, 8'h08};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{1'b1, 3'd3, 3'd2, 3'd4, 1'b1, 4'h6, 8'hAA, 8'hBB, 1'b1, 3'd3, 8'h46, 1'b1, 1'b1, 1'b1, 8'h46, 8'hBB, 3'd4, 4'h6, 8'h10};
    vecs[5]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 4'h7, 8'hFF, 8'hFF, 1'b1, 3'd4, 8'h99, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 4'h7, 8'h00};
    vecs[6]  = '{1'b1, 3'd0, 3'd5, 3'd0, 1'b1, 4'h8, 8'hFF, 8'h21, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h21, 3'd0, 4'h8, 8'h00};
    vecs[7]  = '{1'b1, 3'd1, 3'd2, 3'd5, 1'b1, 4'h9, 8'h51, 8'h52, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h21, 3'd0, 4'h8, 8'h00};
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = '{1'b1, 3'd1, 3'd2, 3'd5, 1'b1, 4'h9, 8'h51, 8'h52, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h51, 8'h52, 3'd5, 4'h9, 8'h20};
    vecs[11] = '{1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 4'hA, 8'h01, 8'h02, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 3'd3, 4'hA, 8'h28};
    vecs[12] = '{1'b1, 3'd6, 3'd7, 3'd3, 1'b1, 4'hB, 8'h66, 8'h77, 1'b1, 3'd3, 8'h33, 1'b1, 1'b1, 1'b1, 8'h66, 8'h77, 3'd3, 4'hB, 8'h28};
    vecs[13] = '{1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 4'hC, 8'h00, 8'h00, 1'b1, 3'd2, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3, 3'd0, 4'hC, 8'h28};
    vecs[14] = '{1'b1, 3'd1, 3'd5, 3'd1, 1'b1, 4'hD, 8'h11, 8'h55, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3, 8'hC3, 3'd0, 4'hC, 8'h28};
    vecs[15] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'hE, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 8'hC3, 3'd0, 4'hC, 8'h28};

    // Reset held for two edges with a valid instruction presented.
    drive(vecs[0], 8'h00);
    rst = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_busy",      int'(bus.busy),      0);
    chk("reset_out_a",     int'(bus.out_a),     0);
    rst = 1'b1;
    #1;
    chk("post_reset_in_ready", int'(bus.in_ready), 1);

    // Table: each record is one cycle; in_ready/ra1 checked before the edge, registers after.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 8'hE0 | 8'(i));
      @(negedge clk);
      chk($sformatf("v%0d_ra1", i),      int'(bus.ra1),      int'(vecs[i].rs1));
      chk($sformatf("v%0d_ra2", i),      int'(bus.ra2),      int'(vecs[i].rs2));
      chk($sformatf("v%0d_in_ready", i), int'(bus.in_ready), int'(vecs[i].x_rdy));
      tick();
      chk($sformatf("v%0d_out_valid", i), int'(bus.out_valid), int'(vecs[i].x_ov));
      chk($sformatf("v%0d_out_a", i),     int'(bus.out_a),     int'(vecs[i].x_a));
      chk($sformatf("v%0d_out_b", i),     int'(bus.out_b),     int'(vecs[i].x_b));
      chk($sformatf("v%0d_out_rd", i),    int'(bus.out_rd),    int'(vecs[i].x_rd));
      chk($sformatf("v%0d_out_op", i),    int'(bus.out_op),    int'(vecs[i].x_op));
      chk($sformatf("v%0d_busy", i),      int'(bus.busy),      int'(vecs[i].x_busy));
    end

    // Issue one more instruction and leave it stalled at the output, then reset mid-stream.
    bus.in_valid  = 1'b1;
    bus.in_rs1    = 3'd0;
    bus.in_rs2    = 3'd0;
    bus.in_rd     = 3'd2;
    bus.in_wen    = 1'b1;
    bus.in_op     = 4'hD;
    bus.in_imm    = 8'h5A;
    bus.wb_we     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    chk("pre_rst_out_imm",   int'(bus.out_imm),   8'h5A);
    chk("pre_rst_out_wen",   int'(bus.out_wen),   1);
    chk("pre_rst_busy",      int'(bus.busy),      8'h2C);

    rst = 1'b0;
    tick();
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy",      int'(bus.busy),      0);
    chk("mid_rst_out_imm",   int'(bus.out_imm),   0);
    chk("mid_rst_out_rd",    int'(bus.out_rd),    0);
    chk("mid_rst_out_wen",   int'(bus.out_wen),   0);
    rst = 1'b1;
    bus.in_rs1 = 3'd2;
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    tick();
    chk("after_rst_issue_valid", int'(bus.out_valid), 1);
    chk("after_rst_issue_busy",  int'(bus.busy),      8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Issue stage directly upstream of the register file in the 8-bit datapath. It accepts decoded instructions over a valid/ready handshake and drives the register file read addresses. It bypasses same-cycle writebacks, stalls on read-after-write hazards using an 8-entry busy scoreboard, and presents registered operands to the execute stage over a second valid/ready handshake.

## Interface
- `DATA_W`, 8, operand and register width
- `ADDR_W`, 3, register address width (8 registers, $0 hard-wired to zero)
- `OP_W`, 4, opaque opcode width, passed through

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous and active-low
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_rs1`, `in_rs2`  in  ADDR_W  source register addresses
- `in_rd`  in  ADDR_W  destination register address
- `in_wen`  in  1  instruction writes `in_rd`
- `in_op`  in  OP_W  opcode, passed through
- `in_imm`  in  DATA_W  immediate, passed through
- `ra1`, `ra2`  out  ADDR_W  register file read addresses
- `rd1`, `rd2`  in  DATA_W  register file combinational read data
- `wb_we`, `wb_addr`, `wb_data`  in  1/ADDR_W/DATA_W  writeback bus; the same signals that drive the register file write port
- `out_valid`  out  1  issued instruction present
- `out_ready`  in  1  execute stage accepts
- `out_a`, `out_b`  out  DATA_W  resolved operands
- `out_rd`, `out_wen`, `out_op`, `out_imm`  out  registered pass-through fields
- `busy`  out  8  scoreboard, for debug; bit n set means $n has a write pending

## Operation
- `ra1` = `in_rs1` and `ra2` = `in_rs2`, combinational and regardless of `in_valid`.
- Operand N resolves by priority:
  - rsN==0 → 0.
  - Else, `wb_we` && `wb_addr`==rsN → `wb_data` (bypass).
  - Else → rdN.
- hazardN = rsN!=0 && busy[rsN] && !(`wb_we` && `wb_addr`==rsN). hazard = hazard1 | hazard2.
- `in_ready` = !hazard && (!`out_valid` || `out_ready`). It never depends on `in_valid`.
- fire = `in_valid` && `in_ready`. On fire, the output register captures the resolved operands and pass-through fields, and `out_valid` is set to 1.
- Else, if `out_ready`, `out_valid` is cleared to 0. Otherwise all outputs hold.
- Scoreboard update each cycle:
  - If `wb_we`, clear busy[`wb_addr`].
  - Then, if fire && `in_wen` && `in_rd`!=0, set busy[`in_rd`]. Set wins over clear on the same bit.
  - busy[0] is constant 0.
- `wb_we` to a register whose busy bit is 0 is legal. The bit stays 0.
- Reset (`rst`==0 at an edge) applies mid-operation too:
  - `out_valid`, `out_a`, `out_b`, `out_rd`, `out_wen`, `out_op`, `out_imm` and `busy` all become 0.
  - Any in-flight instruction is dropped.

## Timing
- Read addresses: 0-cycle. Operands valid on `out_*` 1 cycle after fire.
- Throughput: 1 instruction/cycle when there is no hazard and no backpressure.
- A RAW stall lasts until the cycle in which `wb_we` writes the blocking register. The instruction fires in that same cycle and captures `wb_data` via the bypass, so no extra bubble is added.
- While `out_valid`=1 && `out_ready`=0, all `out_*` hold stable.
- After reset release: `in_ready`=1 in the first cycle, provided `out_valid`=0 and busy=0.

## Structure
- Shared package `riscv8_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS`=8, `OP_W`, and a `reg_addr_t` typedef. It is reused by the register file and the execute stage.
- Sub-module `reg_scoreboard`:
  - Inputs: `clk`, `rst`, clear port (`wb_we`, `wb_addr`), set port (`set_en`, `set_addr`).
  - Output: `busy[7:0]`.
  - Implements the set-wins rule and the constant busy[0]=0.
- Top level holds the bypass muxes, hazard logic and output pipeline register.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, busy=0x00, then `in_ready`=1 after release.
- Basic issue: rd1=0x12, rd2=0x34, issue rs1=1 rs2=2 rd=3 wen=1 → next cycle `out_a`=0x12, `out_b`=0x34, `out_rd`=3, busy=0x08.
- RAW stall and bypass:
  - Next instruction has rs1=3 → `in_ready`=0 for 3 cycles.
  - Pulse `wb_we` with addr=3, data=0x46 → `in_ready`=1 in that cycle.
  - Next cycle: `out_a`=0x46, busy[3]=0.
- $0 handling:
  - rs1=0 with rd1 driven to 0xFF → `out_a`=0x00.
  - rd=0 wen=1 → busy stays 0x00, and a following rs1=0 never stalls.
- Backpressure: `out_valid`=1, `out_ready`=0 for 3 cycles → `in_ready`=0 and `out_*` unchanged. Raise `out_ready` → the queued instruction fires that cycle.
- Simultaneous clear and set:
  - busy[3]=1, `wb_we` addr=3 in the same cycle as issuing rd=3 wen=1 → busy[3]=1 next cycle.
  - Then assert `rst`=0 mid-stream → busy=0x00 and `out_valid`=0.
